mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Synthesizable multi-channel memory responder: the memory end of the GPU's
//  valid/ready program/data memory interface.
//  - Stores a 2^ADDR_BITS x DATA_BITS array and serves independent channels
//    with a configurable response latency.
//  - Used behind the GPU top in FPGA/emulation builds and as the bench memory model.
//  - A backdoor load port preloads the kernel program and data before start.
// PARAMETERS
//  ADDR_BITS     8  address width; depth = 2**ADDR_BITS rows
//  DATA_BITS     8  data width (16 for the program memory instance)
//  NUM_CHANNELS  4  independent request channels
//  LATENCY       2  extra wait cycles between request acceptance and ready; 0..15
//  WRITE_ENABLE  1  0 = read-only instance: write inputs ignored, write_ready tied 0
// PORTS
//  clk                 in   1                        clock, rising edge
//  reset               in   1                        async reset, active-low
//  mem_read_valid      in   [NUM_CHANNELS]           read request per channel
//  mem_read_address    in   [ADDR_BITS] x NUM_CHANNELS  read address per channel
//  mem_read_ready      out  [NUM_CHANNELS]           read data valid / acknowledge
//  mem_read_data       out  [DATA_BITS] x NUM_CHANNELS  read data, valid while ready=1
//  mem_write_valid     in   [NUM_CHANNELS]           write request per channel
//  mem_write_address   in   [ADDR_BITS] x NUM_CHANNELS  write address
//  mem_write_data      in   [DATA_BITS] x NUM_CHANNELS  write data
//  mem_write_ready     out  [NUM_CHANNELS]           write acknowledge
//  load_en             in   1                        backdoor write strobe
//  load_address        in   [ADDR_BITS]              backdoor address
//  load_data           in   [DATA_BITS]              backdoor data
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - all ready=0, all read_data=0, every channel FSM to IDLE, counters=0.
//    - Array contents are NOT reset.
//    - Reset mid-transaction aborts it; an uncommitted write is discarded.
//  - Per-channel FSM states: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
//  - IDLE:
//    - read_valid=1 at edge t: latch address, cnt=LATENCY, go to RD_WAIT.
//    - Otherwise write_valid=1: latch address+data, go to WR_WAIT.
//    - Read has priority if both are valid; the write is served after the read.
//  - *_WAIT:
//    - cnt>0: decrement.
//    - cnt==0: go to *_DONE.
//    - Ready rises at edge t+1+LATENCY (LATENCY=0 gives ready 1 cycle after acceptance).
//  - RD_DONE entry:
//    - read_data <= array[latched addr]; ready=1.
//    - Data and ready are held stable until valid is sampled 0.
//  - WR_DONE entry:
//    - array[latched addr] <= latched data (commit at that edge); ready=1.
//  - *_DONE with valid sampled 0: ready falls at the next edge, back to IDLE (4-phase).
//    - A new request needs at least one IDLE cycle.
//  - Address/data changes after acceptance are ignored until the next IDLE.
//  - Write collisions on one row in the same edge:
//    - load port wins over channels;
//    - among channels, lowest index wins.
//  - Read of a row committed at the same edge returns the OLD value.
//  - WRITE_ENABLE=0: write_valid ignored, write_ready constant 0, load port still active.
//  - Address arithmetic: none; address widths match, no wrap logic required.
//  - Channels are fully independent; no cross-channel arbitration except write collisions.
// STRUCTURE
//  - Package gpu_mem_pkg:
//    - typedef enum logic [2:0] mem_ch_state_t {IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE};
//    - localparam MAX_LATENCY = 15.
//  - Sub-module mem_channel_fsm, one per channel via generate:
//    - contents: FSM, latency counter, latched address/data;
//    - outputs: ready, commit strobe, read row select.
//  - Top owns the array, the read muxes and the prioritized write port.
// TESTING
//  - Reset/idle: hold reset=0 for 3 cycles with valid=1 on all channels
//    -> ready=0, data=0 throughout; after release, ch0 reads 0x10 (preloaded 0xAB)
//    -> ready at edge t+3, data=0xAB.
//  - Latency sweep: LATENCY=0 and LATENCY=5, ch2 read of 0x20=0x5A
//    -> ready at t+1 and t+6; ready held while valid=1; falls 1 cycle after valid drops.
//  - Write then read: ch1 writes 0x33 to 0x40, waits for ready, drops valid;
//    ch3 then reads 0x40 -> 0x33; read of 0x40 in the same commit edge -> old value.
//  - Collision: ch0 and ch3 write 0x01/0x02 to 0x80 simultaneously -> 0x80=0x01;
//    with load_en=1, load_data=0x77 to 0x80 on the same edge -> 0x80=0x77.
//  - Read/write priority: ch0 read_valid and write_valid together
//    -> read completes first, then the write is acked; memory updated once.
//  - Abort: reset asserted during WR_WAIT of ch2 to 0x90 (old 0x11)
//    -> 0x90 stays 0x11; all ready=0 immediately (async).

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and limits for the multi-channel memory responder.
package gpu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_WAIT,
    WR_DONE
  } mem_ch_state_t;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_BITS    = $clog2(MAX_LATENCY + 1);

endpackage

// File: rtl/mem_channel_fsm.sv
// One request channel: 4-phase handshake sequencer with a latency down-counter.
// state   | meaning
// IDLE    | waiting for a request; read wins over write
// RD_WAIT | read accepted, counting down latency
// RD_DONE | read data presented, ready held until valid drops
// WR_WAIT | write accepted, counting down latency
// WR_DONE | write committed, ready held until valid drops
module mem_channel_fsm
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  input  logic                 write_valid,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 read_ready,
  output logic                 write_ready,
  output logic                 rd_capture,
  output logic                 commit,
  output logic [ADDR_BITS-1:0] row_addr,
  output logic [DATA_BITS-1:0] row_data
);

  localparam logic [CNT_BITS-1:0] LAT_INIT = CNT_BITS'(LATENCY);

  mem_ch_state_t        state, state_nxt;
  logic [CNT_BITS-1:0]  cnt_q, cnt_nxt;
  logic [ADDR_BITS-1:0] addr_q, addr_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
    end
  end

  // Address/data are captured only in IDLE so later bus changes are ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    case (state)
      IDLE: begin
        if (read_valid) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = LAT_INIT;
          addr_nxt  = read_address;
        end else if (write_valid) begin
          state_nxt = WR_WAIT;
          cnt_nxt   = LAT_INIT;
          addr_nxt  = write_address;
          data_nxt  = write_data;
        end
      end
      RD_WAIT: begin
        if (cnt_zero) state_nxt = RD_DONE;
        else          cnt_nxt   = cnt_q - 1'b1;
      end
      WR_WAIT: begin
        if (cnt_zero) state_nxt = WR_DONE;
        else          cnt_nxt   = cnt_q - 1'b1;
      end
      RD_DONE: if (!read_valid)  state_nxt = IDLE;
      WR_DONE: if (!write_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read_ready  = (state == RD_DONE);
    write_ready = (state == WR_DONE);
    rd_capture  = (state == RD_WAIT) && cnt_zero;
    commit      = (state == WR_WAIT) && cnt_zero;
    row_addr    = addr_q;
    row_data    = data_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory end of the valid/ready program/data interface: shared array,
// per-channel sequencers, read data registers and a prioritized write port.
module mem_responder
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  input  logic                                   load_en,
  input  logic [ADDR_BITS-1:0]                   load_address,
  input  logic [DATA_BITS-1:0]                   load_data
);

  localparam int   DEPTH = 2 ** ADDR_BITS;
  localparam logic WR_EN = (WRITE_ENABLE != 0);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [NUM_CHANNELS-1:0]                ch_write_valid;
  logic [NUM_CHANNELS-1:0]                ch_write_ready;
  logic [NUM_CHANNELS-1:0]                rd_capture;
  logic [NUM_CHANNELS-1:0]                commit;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] row_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] row_data;

  assign ch_write_valid  = mem_write_valid & {NUM_CHANNELS{WR_EN}};
  assign mem_write_ready = ch_write_ready  & {NUM_CHANNELS{WR_EN}};

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    mem_channel_fsm #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .LATENCY   (LATENCY)
    ) u_fsm (
      .clk           (clk),
      .reset         (reset),
      .read_valid    (mem_read_valid[ch]),
      .read_address  (mem_read_address[ch]),
      .write_valid   (ch_write_valid[ch]),
      .write_address (mem_write_address[ch]),
      .write_data    (mem_write_data[ch]),
      .read_ready    (mem_read_ready[ch]),
      .write_ready   (ch_write_ready[ch]),
      .rd_capture    (rd_capture[ch]),
      .commit        (commit[ch]),
      .row_addr      (row_addr[ch]),
      .row_data      (row_data[ch])
    );
  end

  // Later assignments win: channels scanned high to low, load port last.
  always_ff @(posedge clk) begin
    for (int ch = NUM_CHANNELS - 1; ch >= 0; ch--) begin
      if (commit[ch] && WR_EN) mem_q[row_addr[ch]] <= row_data[ch];
    end
    if (load_en) mem_q[load_address] <= load_data;
  end

  // Nonblocking read of the array yields the pre-commit value on a same-edge hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read_data <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (rd_capture[ch]) mem_read_data[ch] <= mem_q[row_addr[ch]];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (LATENCY 2, 0, 5) share one stimulus bus.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  logic [3:0]      rv, wv;
  logic [3:0][7:0] ra, wa, wd;
  logic            load_en;
  logic [7:0]      load_address, load_data;

  logic [3:0]      rr2, wr2, rr0, wr0, rr5, wr5;
  logic [3:0][7:0] rd2, rd0, rd5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr2), .mem_read_data(rd2),
    .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr2),
    .load_en(load_en), .load_address(load_address), .load_data(load_data));

  mem_responder #(.LATENCY(0)) dut_l0 (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr0), .mem_read_data(rd0),
    .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr0),
    .load_en(load_en), .load_address(load_address), .load_data(load_data));

  mem_responder #(.LATENCY(5)) dut_l5 (
    .clk(clk), .reset(reset),
    .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr5), .mem_read_data(rd5),
    .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr5),
    .load_en(load_en), .load_address(load_address), .load_data(load_data));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    load_en = 1'b1; load_address = addr; load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  // Returns edges from acceptance (k=0) to ready for each instance, -1 on timeout.
  task automatic read_txn(input int ch, input logic [7:0] addr,
                          output int k2, output int k0, output int k5);
    k2 = -1; k0 = -1; k5 = -1;
    rv[ch] = 1'b1; ra[ch] = addr;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (k2 < 0 && rr2[ch]) k2 = n;
      if (k0 < 0 && rr0[ch]) k0 = n;
      if (k5 < 0 && rr5[ch]) k5 = n;
      if (k2 >= 0 && k0 >= 0 && k5 >= 0) break;
    end
  endtask

  task automatic release_read(input int ch);
    rv[ch] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int k2, k0, k5;
    rv = 4'hF; wv = 4'hF;
    for (int c = 0; c < 4; c++) begin ra[c] = 8'h10; wa[c] = 8'h10; wd[c] = 8'hFF; end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({rr2, wr2, rr0, wr0, rr5, wr5} !== 24'h0) begin
        n_bad++; $display("FAIL reset_ready cyc%0d: got %h expected 0", i, {rr2, wr2, rr0, wr0, rr5, wr5});
      end
      n_cmp++;
      if (rd2 !== 32'h0) begin
        n_bad++; $display("FAIL reset_data cyc%0d: got %h expected 0", i, rd2);
      end
    end
    rv = 4'h0; wv = 4'h0;
    reset = 1'b1;
    tick();
    preload(8'h10, 8'hAB);
    preload(8'h20, 8'h5A);
    preload(8'h40, 8'h99);
    preload(8'h50, 8'h44);
    preload(8'h90, 8'h11);
    read_txn(0, 8'h10, k2, k0, k5);
    n_cmp++;
    if (k2 !== 3) begin n_bad++; $display("FAIL first_read_lat: got t+%0d expected t+3", k2); end
    n_cmp++;
    if (rd2[0] !== 8'hAB) begin n_bad++; $display("FAIL first_read_data: got %h expected ab", rd2[0]); end
    release_read(0);
  endtask

  task automatic test_latency();
    int k2, k0, k5;
    read_txn(2, 8'h20, k2, k0, k5);
    n_cmp++;
    if (k0 !== 1) begin n_bad++; $display("FAIL lat0: got t+%0d expected t+1", k0); end
    n_cmp++;
    if (k5 !== 6) begin n_bad++; $display("FAIL lat5: got t+%0d expected t+6", k5); end
    n_cmp++;
    if (k2 !== 3) begin n_bad++; $display("FAIL lat2: got t+%0d expected t+3", k2); end
    n_cmp++;
    if ({rd0[2], rd2[2], rd5[2]} !== 24'h5A5A5A) begin
      n_bad++; $display("FAIL lat_data: got %h expected 5a5a5a", {rd0[2], rd2[2], rd5[2]});
    end
    ra[2] = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({rr0[2], rr2[2], rr5[2], rd0[2], rd5[2]} !== {3'b111, 16'h5A5A}) begin
        n_bad++; $display("FAIL lat_hold cyc%0d: got %b/%h/%h expected 111/5a/5a",
                          i, {rr0[2], rr2[2], rr5[2]}, rd0[2], rd5[2]);
      end
    end
    release_read(2);
    n_cmp++;
    if ({rr0[2], rr2[2], rr5[2]} !== 3'b000) begin
      n_bad++; $display("FAIL lat_fall: got %b expected 000", {rr0[2], rr2[2], rr5[2]});
    end
  endtask

  task automatic test_write_read();
    int k2, k0, k5;
    wv[1] = 1'b1; wa[1] = 8'h40; wd[1] = 8'h33;
    rv[3] = 1'b1; ra[3] = 8'h40;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (rr2[3] && wr2[1] && rr0[3] && wr0[1] && rr5[3] && wr5[1]) break;
    end
    n_cmp++;
    if ({rd0[3], rd2[3], rd5[3]} !== 24'h999999) begin
      n_bad++; $display("FAIL same_edge_old: got %h expected 999999", {rd0[3], rd2[3], rd5[3]});
    end
    wv[1] = 1'b0; rv[3] = 1'b0;
    tick();
    read_txn(3, 8'h40, k2, k0, k5);
    n_cmp++;
    if ({rd0[3], rd2[3], rd5[3]} !== 24'h333333) begin
      n_bad++; $display("FAIL write_then_read: got %h expected 333333", {rd0[3], rd2[3], rd5[3]});
    end
    release_read(3);
  endtask

  task automatic test_collision();
    int k2, k0, k5;
    wv[0] = 1'b1; wa[0] = 8'h80; wd[0] = 8'h01;
    wv[3] = 1'b1; wa[3] = 8'h80; wd[3] = 8'h02;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (wr2[0] && wr2[3] && wr0[0] && wr0[3] && wr5[0] && wr5[3]) break;
    end
    wv = 4'h0;
    tick();
    read_txn(1, 8'h80, k2, k0, k5);
    n_cmp++;
    if ({rd0[1], rd2[1], rd5[1]} !== 24'h010101) begin
      n_bad++; $display("FAIL chan_collision: got %h expected 010101", {rd0[1], rd2[1], rd5[1]});
    end
    release_read(1);
    // Load lands on the LATENCY=2 commit edge (k=3).
    wv[0] = 1'b1; wa[0] = 8'h80; wd[0] = 8'h03;
    tick(); tick(); tick();
    load_en = 1'b1; load_address = 8'h80; load_data = 8'h77;
    tick();
    load_en = 1'b0;
    n_cmp++;
    if (wr2[0] !== 1'b1) begin n_bad++; $display("FAIL load_coll_ack: got %b expected 1", wr2[0]); end
    for (int n = 0; n < 10; n++) begin
      if (wr5[0]) break;
      tick();
    end
    wv[0] = 1'b0;
    tick();
    read_txn(1, 8'h80, k2, k0, k5);
    n_cmp++;
    if ({rd0[1], rd2[1]} !== 16'h7777) begin
      n_bad++; $display("FAIL load_collision: got %h expected 7777", {rd0[1], rd2[1]});
    end
    release_read(1);
  endtask

  task automatic test_priority();
    int k2, k0, k5;
    rv[0] = 1'b1; ra[0] = 8'h50;
    wv[0] = 1'b1; wa[0] = 8'h50; wd[0] = 8'h66;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (rr2[0] && rr0[0] && rr5[0]) break;
    end
    n_cmp++;
    if ({rd0[0], rd2[0], rd5[0]} !== 24'h444444) begin
      n_bad++; $display("FAIL prio_read_data: got %h expected 444444", {rd0[0], rd2[0], rd5[0]});
    end
    n_cmp++;
    if ({wr0[0], wr2[0], wr5[0]} !== 3'b000) begin
      n_bad++; $display("FAIL prio_no_wr_ack: got %b expected 000", {wr0[0], wr2[0], wr5[0]});
    end
    rv[0] = 1'b0;
    tick();
    n_cmp++;
    if ({rr0[0], rr2[0], rr5[0]} !== 3'b000) begin
      n_bad++; $display("FAIL prio_rd_fall: got %b expected 000", {rr0[0], rr2[0], rr5[0]});
    end
    for (int n = 0; n < 25; n++) begin
      tick();
      if (wr2[0] && wr0[0] && wr5[0]) break;
    end
    n_cmp++;
    if ({wr0[0], wr2[0], wr5[0]} !== 3'b111) begin
      n_bad++; $display("FAIL prio_wr_ack: got %b expected 111", {wr0[0], wr2[0], wr5[0]});
    end
    wv[0] = 1'b0;
    tick();
    read_txn(1, 8'h50, k2, k0, k5);
    n_cmp++;
    if ({rd0[1], rd2[1], rd5[1]} !== 24'h666666) begin
      n_bad++; $display("FAIL prio_mem: got %h expected 666666", {rd0[1], rd2[1], rd5[1]});
    end
    release_read(1);
  endtask

  task automatic test_abort();
    int k2, k0, k5;
    wv[2] = 1'b1; wa[2] = 8'h90; wd[2] = 8'hEE;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({rr0, wr0, rr2, wr2, rr5, wr5} !== 24'h0) begin
      n_bad++; $display("FAIL abort_async: got %h expected 0", {rr0, wr0, rr2, wr2, rr5, wr5});
    end
    n_cmp++;
    if (rd2 !== 32'h0) begin n_bad++; $display("FAIL abort_data: got %h expected 0", rd2); end
    tick(); tick();
    wv = 4'h0;
    reset = 1'b1;
    tick();
    read_txn(0, 8'h90, k2, k0, k5);
    n_cmp++;
    if ({rd2[0], rd5[0]} !== 16'h1111) begin
      n_bad++; $display("FAIL abort_discard: got %h expected 1111", {rd2[0], rd5[0]});
    end
    release_read(0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    load_en = 1'b0; load_address = '0; load_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    test_reset();
    test_latency();
    test_write_read();
    test_collision();
    test_priority();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
